// File: rtl/sram_wr_arb.sv
// Two-requester SRAM write arbiter with a one-word output register; bursts are capped
// at BURST_MAX words when the other side is waiting, and a stalled owner keeps its grant.
module sram_wr_arb #(
  parameter int BURST_MAX = 16,
  parameter int CNT_W     = 5
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req0_we,
  input  logic [20:0] req0_addr,
  input  logic [31:0] req0_data,
  output logic        req0_full,
  input  logic        req1_we,
  input  logic [20:0] req1_addr,
  input  logic [31:0] req1_data,
  output logic        req1_full,
  output logic [20:0] data_w_address,
  output logic [31:0] data_w,
  output logic        data_w_we,
  input  logic        data_w_full,
  output logic [1:0]  grant,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_last;
  logic [CNT_W-1:0] r_bcnt;
  logic [CNT_W-1:0] w_bcnt_nxt;
  logic [CNT_W-1:0] w_bcnt_inc;
  logic             r_ovalid;
  logic [20:0]      r_addr;
  logic [31:0]      r_data;
  logic             w_ready;
  logic             w_acc0;
  logic             w_acc1;
  logic             w_acc;
  logic             w_burst_end;

  assign w_ready     = !r_ovalid || !data_w_full;
  assign w_acc0      = (r_state == G0) && req0_we && w_ready;
  assign w_acc1      = (r_state == G1) && req1_we && w_ready;
  assign w_acc       = w_acc0 || w_acc1;
  assign w_bcnt_inc  = r_bcnt + 1'b1;
  assign w_burst_end = w_acc && (w_bcnt_inc == CNT_W'(BURST_MAX));

  always_comb begin
    w_state_nxt = r_state;
    w_bcnt_nxt  = r_bcnt;
    case (r_state)
      IDLE: begin
        w_bcnt_nxt = '0;
        // r_last high means requester 1 went last, so requester 0 wins a tie
        if (req0_we && req1_we) w_state_nxt = r_last ? G0 : G1;
        else if (req0_we)       w_state_nxt = G0;
        else if (req1_we)       w_state_nxt = G1;
      end
      G0: begin
        if (!req0_we) begin
          w_bcnt_nxt  = '0;
          w_state_nxt = req1_we ? G1 : IDLE;
        end else if (w_burst_end) begin
          w_bcnt_nxt = '0;
          if (req1_we) w_state_nxt = G1;
        end else if (w_acc) begin
          w_bcnt_nxt = w_bcnt_inc;
        end
      end
      G1: begin
        if (!req1_we) begin
          w_bcnt_nxt  = '0;
          w_state_nxt = req0_we ? G0 : IDLE;
        end else if (w_burst_end) begin
          w_bcnt_nxt = '0;
          if (req0_we) w_state_nxt = G0;
        end else if (w_acc) begin
          w_bcnt_nxt = w_bcnt_inc;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_bcnt_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= IDLE;
      r_bcnt  <= '0;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_bcnt  <= w_bcnt_nxt;
      if (w_state_nxt == G0 && r_state != G0)      r_last <= 1'b0;
      else if (w_state_nxt == G1 && r_state != G1) r_last <= 1'b1;
    end
  end

  // Load and drain in the same cycle keeps ovalid set, so back-to-back words have no bubble
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_ovalid <= 1'b0;
      r_addr   <= '0;
      r_data   <= '0;
    end else if (w_acc) begin
      r_ovalid <= 1'b1;
      r_addr   <= w_acc0 ? req0_addr : req1_addr;
      r_data   <= w_acc0 ? req0_data : req1_data;
    end else if (r_ovalid && !data_w_full) begin
      r_ovalid <= 1'b0;
    end
  end

  assign grant          = {r_state == G1, r_state == G0};
  assign req0_full      = !((r_state == G0) && w_ready);
  assign req1_full      = !((r_state == G1) && w_ready);
  assign data_w_we      = r_ovalid;
  assign data_w_address = r_addr;
  assign data_w         = r_data;
  assign busy           = (r_state != IDLE) || r_ovalid;

endmodule

// File: doc/sram_wr_arb.md
SRAM_WR_ARB -- requirements
Module: sram_wr_arb

Interface
REQ-001 The block SHALL have parameter BURST_MAX, default 16, meaning the maximum number of words accepted from one requester per grant while the other requester waits.
REQ-002 The block SHALL have parameter CNT_W, default 5, meaning the burst counter width; CNT_W SHALL hold BURST_MAX.
REQ-003 CLK  input  1  clock; all state changes on the rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-low.
REQ-005 req0_we  input  1  requester 0 (picture loader) write request.
REQ-006 req0_addr  input  21  requester 0 word address, SRAM address bits [21:1].
REQ-007 req0_data  input  32  requester 0 write data.
REQ-008 req0_full  output  1  requester 0 stall; high means the word is not taken this cycle.
REQ-009 req1_we, req1_addr, req1_data, req1_full SHALL match REQ-005..REQ-008 for requester 1 (draw engine).
REQ-010 data_w_address  output  21  SRAM write-port address.
REQ-011 data_w  output  32  SRAM write-port data.
REQ-012 data_w_we  output  1  SRAM write-port write enable.
REQ-013 data_w_full  input  1  SRAM write port cannot accept a word this cycle.
REQ-014 grant  output  2  one-hot current owner: 01 for requester 0, 10 for requester 1, 00 for none.
REQ-015 busy  output  1  high when grant is not 00 or the output register holds a word.

Function
REQ-016 The state machine SHALL have exactly three states: IDLE (grant 00), G0 (grant 01) and G1 (grant 10).
REQ-017 The output stage SHALL be a one-word register with flag ovalid, where ready = !ovalid || !data_w_full.
REQ-018 data_w_we SHALL equal ovalid; data_w_address and data_w SHALL come directly from the output register.
REQ-019 Downstream acceptance SHALL occur in any cycle with ovalid=1 and data_w_full=0.
REQ-020 The granted requester's word SHALL be accepted in a cycle when its we=1 and ready=1; the register loads addr/data and ovalid is set on the next edge.
REQ-021 If a downstream acceptance and an upstream acceptance occur in the same cycle, ovalid SHALL stay 1 and the register SHALL take the new word, with no bubble.
REQ-022 If a downstream acceptance occurs with no upstream acceptance, ovalid SHALL clear.
REQ-023 reqN_full SHALL be !(grant==N && ready), evaluated combinationally; a non-granted requester always sees full=1.
REQ-024 A write request SHALL never be accepted in IDLE; the first word after a grant change is accepted no earlier than the cycle after grant is registered.
REQ-025 IDLE SHALL go to G0 or G1 when either we is high; if both are high it SHALL go to the requester not recorded in last_grant.
REQ-026 last_grant SHALL be updated on every entry to G0 or G1.
REQ-027 In GN with reqN_we=0: the state SHALL go to the other grant if the other we=1, else to IDLE.
REQ-028 Each upstream acceptance SHALL increment burst counter bcnt.
REQ-029 When an acceptance makes bcnt reach BURST_MAX: the state SHALL switch to the other grant if the other we=1; otherwise it SHALL stay in GN with bcnt cleared.
REQ-030 bcnt SHALL clear on every grant change and in IDLE.
REQ-031 A stalled requester (we=1, full=1) SHALL keep its grant indefinitely while data_w_full holds; a grant switch happens only through REQ-027 or REQ-029.
REQ-032 Words from one requester SHALL reach data_w in acceptance order; no word is dropped or duplicated.

Reset
REQ-033 When RST is low: state SHALL be IDLE, grant 00, ovalid 0, data_w_we 0, data_w_address 0, data_w 0, bcnt 0.
REQ-034 When RST is low: last_grant SHALL indicate requester 1, so requester 0 wins the first tie.
REQ-035 When RST is low: req0_full and req1_full SHALL be 1 and busy SHALL be 0.
REQ-036 Reset asserted mid-burst SHALL discard the output-register word with no write issued; after release the state machine SHALL restart from IDLE.

Verification
REQ-037 Single requester: req0_we held with 4 words addr 0x000000..0x000003, data_w_full=0 -> grant=01 one cycle later; 4 consecutive data_w_we pulses in order; IDLE after req0_we drops.
REQ-038 Tie from reset: req0_we and req1_we both rise together -> grant=01 first; after 16 accepted words grant=10; after 16 requester-1 words grant returns to 01.
REQ-039 Backpressure: data_w_full=1 for 5 cycles while data_w_we=1 -> data_w/address held stable; req0_full=1; no acceptance; bcnt unchanged; the word is written once when full drops.
REQ-040 Burst wrap, no contender: req0 streams 40 words, req1 idle -> grant stays 01 throughout; bcnt wraps at 16 twice; 40 writes with no gaps.
REQ-041 Early release: req1 granted, req1_we drops after 3 words while req0_we=1 -> grant=01 on the next cycle; bcnt=0; the requester-1 word in the register is still written before requester-0 data.
REQ-042 Reset mid-burst: RST low while ovalid=1 -> data_w_we=0 immediately and grant=00; after release the first tie goes to requester 0.
